// File: rtl/line_buf_pkg.sv
// line_buf_pkg: shared types and default geometry for the 3x3 line-buffer sequencer.
package line_buf_pkg;

    localparam int DEF_IMG_WIDTH       = 720;
    localparam int DEF_IMG_HEIGHT      = 540;
    localparam int DEF_GRAY_DATA_WIDTH = 8;
    localparam int PAD_W               = DEF_IMG_WIDTH + 2;
    localparam int PAD_H               = DEF_IMG_HEIGHT + 2;
    localparam int LB_DEPTH            = 2 * PAD_W + 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    typedef logic [DEF_GRAY_DATA_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/line_buf_ctrl_if.sv
// line_buf_ctrl_if: FIFO, line-buffer and window handshake between the sequencer and its neighbours.
interface line_buf_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int COL_W  = 10,
    parameter int ROW_W  = 10
);
    logic              start;
    logic [DATA_W-1:0] in_dout;
    logic              in_empty;
    logic              in_rd_en;
    logic              out_afull;
    logic              sr_clk_en;
    logic [DATA_W-1:0] sr_din;
    logic              win_valid;
    logic [ROW_W-1:0]  win_row;
    logic [COL_W-1:0]  win_col;
    logic              busy;
    logic              done;

    modport master (
        input  start, in_dout, in_empty, out_afull,
        output in_rd_en, sr_clk_en, sr_din, win_valid, win_row, win_col, busy, done
    );

    modport slave (
        output start, in_dout, in_empty, out_afull,
        input  in_rd_en, sr_clk_en, sr_din, win_valid, win_row, win_col, busy, done
    );
endinterface

// File: rtl/line_buf_ctrl_pad_raster_cnt.sv
// pad_raster_cnt: row/column walker over the zero-padded frame with pad and last-position flags.
module pad_raster_cnt #(
    parameter int PW    = 722,
    parameter int PH    = 542,
    parameter int COL_W = 10,
    parameter int ROW_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [ROW_W-1:0] r,
    output logic [COL_W-1:0] c,
    output logic             pad,
    output logic             last
);
    localparam logic [COL_W-1:0] C_LAST = COL_W'(PW - 1);
    localparam logic [ROW_W-1:0] R_LAST = ROW_W'(PH - 1);

    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;
    logic             col_end, row_end;

    assign col_end = c_q == C_LAST;
    assign row_end = r_q == R_LAST;
    assign r       = r_q;
    assign c       = c_q;
    assign pad     = r_q == '0 || row_end || c_q == '0 || col_end;
    assign last    = row_end && col_end;

    // Advance one position per shift; the row wraps too so the counter idles at (0,0).
    always_comb begin
        c_d = clr ? '0 : !en ? c_q : col_end ? '0 : c_q + 1'b1;
        r_d = clr ? '0 : !(en && col_end) ? r_q : row_end ? '0 : r_q + 1'b1;
    end

    // Position registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
            c_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
        end
    end
endmodule

// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: raster sequencer for the 3x3 window line buffer with zero padding and backpressure.
// Optional LINE_BUF_CTRL_STALL_CNT_EN adds a saturating stall_cycles counter output.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int IMG_WIDTH       = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT      = DEF_IMG_HEIGHT,
    parameter int GRAY_DATA_WIDTH = DEF_GRAY_DATA_WIDTH,
    parameter int COL_W           = $clog2(IMG_WIDTH + 2),
    parameter int ROW_W           = $clog2(IMG_HEIGHT + 2)
) (
    input  logic clk,
    input  logic rst,
    line_buf_ctrl_if.master bus
`ifdef LINE_BUF_CTRL_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    state_t           state_q, state_d;
    logic             win_valid_q, win_valid_d;
    logic [ROW_W-1:0] win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic             done_q, done_d;
    logic [ROW_W-1:0] r;
    logic [COL_W-1:0] c;
    logic             pad, last, run, wv, shift, start_ok;
    logic [GRAY_DATA_WIDTH-1:0] pix;

    assign run      = state_q == RUN;
    assign start_ok = state_q == IDLE && bus.start;
    assign wv       = r >= 2 && c >= 2;
    assign shift    = run && (pad || !bus.in_empty) && !(wv && bus.out_afull);
    assign pix      = run && !pad ? bus.in_dout : '0;

    pad_raster_cnt #(
        .PW(IMG_WIDTH + 2),
        .PH(IMG_HEIGHT + 2),
        .COL_W(COL_W),
        .ROW_W(ROW_W)
    ) u_cnt (
        .clk(clk),
        .rst(rst),
        .clr(start_ok),
        .en(shift),
        .r(r),
        .c(c),
        .pad(pad),
        .last(last)
    );

    assign bus.sr_clk_en = shift;
    assign bus.in_rd_en  = shift && !pad;
    assign bus.sr_din    = pix;
    assign bus.win_valid = win_valid_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = done_q;

    // Next state and the window flag/coordinates that line up with the taps after this edge.
    always_comb begin
        state_d     = state_q == IDLE ? (bus.start ? RUN : IDLE)
                    : state_q == RUN  ? (shift && last ? DRAIN : RUN)
                    : IDLE;
        win_valid_d = shift && wv;
        win_row_d   = shift && wv ? r - ROW_W'(2) : win_row_q;
        win_col_d   = shift && wv ? c - COL_W'(2) : win_col_q;
        done_d      = shift && last;
    end

    // Control and registered window outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            done_q      <= done_d;
        end
    end

`ifdef LINE_BUF_CTRL_STALL_CNT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_cycles = stall_q;

    // Count stalled RUN cycles, saturating, restarting on each accepted frame.
    always_comb begin
        stall_d = start_ok ? '0 : run && !shift && !(&stall_q) ? stall_q + 1'b1 : stall_q;
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`else
`endif
endmodule

// File: tb/tb_line_buf_ctrl.sv
// tb_line_buf_ctrl: directed bench for line_buf_ctrl on a 4x3 frame with underflow, backpressure and reset.
module tb_line_buf_ctrl;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int PW   = W + 2;
    localparam int PH   = H + 2;
    localparam int CW   = $clog2(PW);
    localparam int RW   = $clog2(PH);
    localparam int NPIX = W * H;
    localparam int LBD  = 2 * PW + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    line_buf_ctrl_if #(.DATA_W(8), .COL_W(CW), .ROW_W(RW)) bus ();

`ifdef LINE_BUF_CTRL_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    line_buf_ctrl #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .GRAY_DATA_WIDTH(8),
        .COL_W(CW),
        .ROW_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LINE_BUF_CTRL_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    int   n_chk = 0, n_pass = 0;
    int   rd_ptr = 0;
    logic pop_pending = 1'b0;
    logic hold_empty = 1'b0;
    int   cyc, shifts, pops, wins, dones, stalls;
    int   first_sh, last_sh, s22, first_win, done_cyc, busy_fall;
    int   done_row, done_col, exp_pix, pr, pc;
    logic [7:0] lb [LBD];

    assign bus.in_dout  = 8'(rd_ptr + 1);
    assign bus.in_empty = hold_empty || rd_ptr >= NPIX;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_stats();
        cyc = 0; shifts = 0; pops = 0; wins = 0; dones = 0; stalls = 0;
        first_sh = 0; last_sh = 0; s22 = 0; first_win = 0; done_cyc = 0; busy_fall = 0;
        done_row = 0; done_col = 0; exp_pix = 1; pr = 0; pc = 0;
        rd_ptr = 0; pop_pending = 1'b0;
    endtask

    // FIFO model: pop the head on the edge after a sampled read enable.
    always @(posedge clk) begin
        if (pop_pending) begin
            rd_ptr <= rd_ptr + 1;
            pop_pending = 1'b0;
        end
    end

    // Monitor: sample mid-cycle, track the padded raster and a model line buffer.
    always @(negedge clk) begin
        if (!rst) begin
            logic is_pad;
            cyc++;
            is_pad = pr == 0 || pr == PH - 1 || pc == 0 || pc == PW - 1;
            if (bus.win_valid) begin
                chk("win_pos", {bus.win_row, bus.win_col}, {RW'(wins / W), CW'(wins % W)});
                if (wins == 0) begin
                    first_win = cyc;
                    chk("taps00", {lb[14], lb[13], lb[12], lb[8], lb[7], lb[6], lb[2], lb[1], lb[0]},
                        {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd5, 8'd6});
                end
                wins++;
            end
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
                done_row = int'(bus.win_row);
                done_col = int'(bus.win_col);
            end
            if (bus.busy && !bus.done && !bus.sr_clk_en) stalls++;
            chk("rd_en", bus.in_rd_en, bus.sr_clk_en && !is_pad);
            if (bus.in_rd_en) begin
                pops++;
                pop_pending = 1'b1;
            end
            if (bus.sr_clk_en) begin
                chk(is_pad ? "sr_din_pad" : "sr_din_pix", bus.sr_din, is_pad ? 8'd0 : 8'(exp_pix));
                if (!is_pad) exp_pix++;
                if (pr == 2 && pc == 2) s22 = cyc;
                if (shifts == 0) first_sh = cyc;
                last_sh = cyc;
                for (int i = LBD - 1; i > 0; i--) lb[i] = lb[i-1];
                lb[0] = bus.sr_din;
                shifts++;
                if (pc == PW - 1) begin
                    pc = 0;
                    pr = pr == PH - 1 ? 0 : pr + 1;
                end else pc++;
            end
            if (!bus.busy && busy_fall == 0 && dones > 0) busy_fall = cyc;
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        clear_stats();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_shifts(input int n);
        int k = 0;
        while (shifts < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_shifts", shifts >= n, 1);
    endtask

    task automatic wait_end();
        int k = 0;
        while (busy_fall == 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        chk("frame_timeout", busy_fall != 0, 1);
    endtask

    task automatic check_frame(input int span, input int stall_n);
        chk("shifts", shifts, 30);
        chk("pops", pops, 12);
        chk("wins", wins, 12);
        chk("dones", dones, 1);
        chk("done_win", {done_row[7:0], done_col[7:0]}, {8'd2, 8'd3});
        chk("shift_span", last_sh - first_sh + 1, span);
        chk("first_win_lat", first_win - s22, 1);
        chk("done_lat", done_cyc - last_sh, 1);
        chk("busy_fall", busy_fall - done_cyc, 1);
        chk("stalls", stalls, stall_n);
`ifdef LINE_BUF_CTRL_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, stall_n);
`endif
    endtask

    task automatic chk_rst_outs(input string tag);
        chk(tag, {bus.sr_clk_en, bus.in_rd_en, bus.sr_din, bus.win_valid, bus.win_row,
                  bus.win_col, bus.busy, bus.done}, 0);
`ifdef LINE_BUF_CTRL_STALL_CNT_EN
        chk({tag, "_stall"}, stall_cycles, 0);
`endif
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.out_afull = 1'b0;
        for (int i = 0; i < LBD; i++) lb[i] = 8'hAA;
        clear_stats();
        #12;
        chk_rst_outs("reset_outs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Free-running frame.
        start_frame();
        wait_end();
        check_frame(30, 0);

        // Input empty from the start: pads still shift, interior (1,1) stalls 5 cycles.
        hold_empty = 1'b1;
        start_frame();
        wait_shifts(7);
        repeat (5) @(posedge clk);
        #1 hold_empty = 1'b0;
        wait_end();
        check_frame(35, 5);

        // Backpressure at window position (2,2) for 3 cycles, plus a start while busy.
        start_frame();
        wait_shifts(10);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_shifts(14);
        bus.out_afull = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.out_afull = 1'b0;
        wait_end();
        check_frame(33, 3);

        // Reset in the middle of row 2, then a clean frame.
        start_frame();
        wait_shifts(12);
        rst = 1'b1;
        #1 chk_rst_outs("midrst_async");
        @(negedge clk);
        chk_rst_outs("midrst_hold");
        @(posedge clk); #1;
        rst = 1'b0;
        start_frame();
        wait_end();
        check_frame(30, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
